// File: rtl/vga_scan_engine_if.sv
// vga_scan_engine_if
//   Groups the scan engine's non-clock signals: scan enable, framebuffer
//   read port, VGA pins and the raw counter taps.
// Ports (signals):
//   iEnable     - scan enable (low = idle, counters cleared)
//   oRdCol      - framebuffer read column (scaled)
//   oRdRow      - framebuffer read row (scaled)
//   iRGB        - framebuffer data returned for the issued address
//   VGA_HSYNC   - horizontal sync pin
//   VGA_VSYNC   - vertical sync pin
//   VGA_RGB     - pixel colour pins (0 while blanked)
//   oFrameStart - one-Clock pulse at the start of each frame
//   oPixelCount - raw horizontal counter
//   oLineCount  - raw vertical counter
// Modports:
//   master - the scan engine itself
//   slave  - the surrounding system (RAM wrapper, pins, enable source)
interface vga_scan_engine_if #(
    parameter int RGB_W = 3
);
    logic             iEnable;
    logic [10:0]      oRdCol;
    logic [9:0]       oRdRow;
    logic [RGB_W-1:0] iRGB;
    logic             VGA_HSYNC;
    logic             VGA_VSYNC;
    logic [RGB_W-1:0] VGA_RGB;
    logic             oFrameStart;
    logic [10:0]      oPixelCount;
    logic [9:0]       oLineCount;

    modport master (
        input  iEnable,
        input  iRGB,
        output oRdCol,
        output oRdRow,
        output VGA_HSYNC,
        output VGA_VSYNC,
        output VGA_RGB,
        output oFrameStart,
        output oPixelCount,
        output oLineCount
    );

    modport slave (
        output iEnable,
        output iRGB,
        input  oRdCol,
        input  oRdRow,
        input  VGA_HSYNC,
        input  VGA_VSYNC,
        input  VGA_RGB,
        input  oFrameStart,
        input  oPixelCount,
        input  oLineCount
    );
endinterface

// File: rtl/vga_scan_engine.sv
// vga_scan_engine
//   Parametrised VGA scan engine. Divides Clock down to a pixel tick, runs
//   programmable horizontal/vertical counters, issues (optionally scaled)
//   framebuffer read addresses and realigns sync/blank to the RAM read
//   latency so that syncs and colour leave on the same Clock edge.
// Ports:
//   Clock - system clock
//   Reset - asynchronous, active-high reset
//   bus   - vga_scan_engine_if.master (enable, read port, VGA pins, counters)
// Timing notes:
//   The read address for counter value (h,v) is registered on the tick that
//   consumes (h,v). iRGB must hold the matching data at the tick edge RD_LAT
//   ticks after that, which is when the delayed blank/sync flags reach the
//   end of the RD_LAT-stage delay line and the output registers load.
module vga_scan_engine #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int RGB_W      = 3,
    parameter int SCALE_LOG2 = 0,
    parameter int RD_LAT     = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    vga_scan_engine_if.master bus
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // A one-bit divider is kept even for CLK_DIV=1; it simply stays at 0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_END   = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END  = 11'(H_VISIBLE + H_FP + H_SYNC);

    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_END   = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SYNC_BEG  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  V_SYNC_END  = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = !SYNC_ON;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [10:0]       h_cnt;
    logic [9:0]        v_cnt;

    logic              active;
    logic              hs_raw;
    logic              vs_raw;

    logic [10:0]       rd_col;
    logic [9:0]        rd_row;
    logic [RD_LAT-1:0] dly_active;
    logic [RD_LAT-1:0] dly_hs;
    logic [RD_LAT-1:0] dly_vs;
    logic [RGB_W-1:0]  rgb_q;
    logic              hsync_q;
    logic              vsync_q;
    logic              frame_start_q;

    assign tick   = (div_cnt == DIV_LAST);
    assign active = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    assign hs_raw = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs_raw = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

    // Pixel-tick divider
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_cnt <= '0;
        end else if (!bus.iEnable) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Horizontal / vertical counters
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!bus.iEnable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // Read address, latency-matching delay line and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_col        <= '0;
            rd_row        <= '0;
            dly_active    <= '0;
            dly_hs        <= '0;
            dly_vs        <= '0;
            rgb_q         <= '0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            frame_start_q <= 1'b0;
        end else if (!bus.iEnable) begin
            rd_col        <= '0;
            rd_row        <= '0;
            dly_active    <= '0;
            dly_hs        <= '0;
            dly_vs        <= '0;
            rgb_q         <= '0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            frame_start_q <= 1'b0;
        end else begin
            // Evaluated every Clock so the pulse is exactly one Clock wide.
            frame_start_q <= tick && (h_cnt == 11'd0) && (v_cnt == 10'd0);
            if (tick) begin
                // Address holds its last visible value through blanking.
                if (active) begin
                    rd_col <= h_cnt >> SCALE_LOG2;
                    rd_row <= v_cnt >> SCALE_LOG2;
                end
                // Shift left; bit 0 is the newest sample, MSB the oldest.
                dly_active <= (dly_active << 1) | RD_LAT'(active);
                dly_hs     <= (dly_hs << 1) | RD_LAT'(hs_raw);
                dly_vs     <= (dly_vs << 1) | RD_LAT'(vs_raw);
                rgb_q      <= dly_active[RD_LAT-1] ? bus.iRGB : '0;
                hsync_q    <= dly_hs[RD_LAT-1] ? SYNC_ON : SYNC_OFF;
                vsync_q    <= dly_vs[RD_LAT-1] ? SYNC_ON : SYNC_OFF;
            end
        end
    end

    assign bus.oRdCol      = rd_col;
    assign bus.oRdRow      = rd_row;
    assign bus.VGA_RGB     = rgb_q;
    assign bus.VGA_HSYNC   = hsync_q;
    assign bus.VGA_VSYNC   = vsync_q;
    assign bus.oFrameStart = frame_start_q;
    assign bus.oPixelCount = h_cnt;
    assign bus.oLineCount  = v_cnt;

endmodule

// File: tb/tb_vga_scan_engine.sv
module tb_vga_scan_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;

    // dut_a: defaults. dut_b: CLK_DIV=1, short frame, 2x scale, RD_LAT=2.
    // dut_c: default timing with CLK_DIV=4.
    vga_scan_engine_if #(.RGB_W(3)) bus_a ();
    vga_scan_engine_if #(.RGB_W(3)) bus_b ();
    vga_scan_engine_if #(.RGB_W(3)) bus_c ();

    vga_scan_engine dut_a (.Clock(clk), .Reset(rst_a), .bus(bus_a));

    vga_scan_engine #(
        .CLK_DIV(1), .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALE_LOG2(1), .RD_LAT(2)
    ) dut_b (.Clock(clk), .Reset(rst_b), .bus(bus_b));

    vga_scan_engine #(.CLK_DIV(4)) dut_c (.Clock(clk), .Reset(rst_c), .bus(bus_c));

    // Reference timing for dut_b
    localparam int BH_TOTAL = 800;
    localparam int BH_VIS   = 640;
    localparam int BH_SB    = 656;
    localparam int BH_SE    = 752;
    localparam int BV_TOTAL = 8;
    localparam int BV_VIS   = 4;
    localparam int BV_SB    = 5;
    localparam int BV_SE    = 7;
    localparam int B_LAT    = 2;

    // Framebuffer model for dut_b: returns col[2:0], one register stage so the
    // data is stable at the tick edge RD_LAT ticks after the address.
    logic [2:0] ram_q = 3'd0;
    always @(posedge clk or posedge rst_b) begin
        if (rst_b)              ram_q <= 3'd0;
        else if (bus_b.iEnable) ram_q <= bus_b.oRdCol[2:0];
    end
    assign bus_b.iRGB = ram_q;
    assign bus_a.iRGB = 3'b111;
    assign bus_c.iRGB = 3'b101;

    typedef struct {
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
    } exp_t;
    exp_t sb_q[$];

    int max_col = 0;
    int max_row = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic hs_of(input int sel);
        if (sel == 0) return bus_a.VGA_HSYNC;
        return bus_c.VGA_HSYNC;
    endfunction

    function automatic logic [10:0] pix_of(input int sel);
        if (sel == 0) return bus_a.oPixelCount;
        return bus_c.oPixelCount;
    endfunction

    // Scoreboard run on dut_b from a cleared state (counters 0,0, delay line empty).
    task automatic sb_run(input int n_ticks);
        int mh, mv;
        logic [10:0] mcol;
        logic [9:0]  mrow;
        logic mfs;
        bit   act;
        exp_t e, got;
        mh = 0; mv = 0; mcol = '0; mrow = '0;
        sb_q.delete();
        for (int i = 0; i < B_LAT; i++) begin
            e.hs = 1'b1; e.vs = 1'b1; e.rgb = 3'd0;
            sb_q.push_back(e);
        end
        if (!bus_b.iEnable) begin
            @(negedge clk);
            bus_b.iEnable = 1'b1;
        end
        for (int t = 0; t < n_ticks; t++) begin
            @(posedge clk);
            act   = (mh < BH_VIS) && (mv < BV_VIS);
            e.hs  = !((mh >= BH_SB) && (mh < BH_SE));
            e.vs  = !((mv >= BV_SB) && (mv < BV_SE));
            e.rgb = act ? 3'((mh >> 1) & 7) : 3'd0;
            sb_q.push_back(e);
            mfs = (mh == 0) && (mv == 0);
            if (act) begin
                mcol = 11'(mh >> 1);
                mrow = 10'(mv >> 1);
            end
            mh++;
            if (mh == BH_TOTAL) begin
                mh = 0;
                mv++;
                if (mv == BV_TOTAL) mv = 0;
            end
            #1;
            got = sb_q.pop_front();
            checks += 8;
            if (bus_b.VGA_HSYNC !== got.hs) begin
                errors++; $display("FAIL sb_hsync t=%0d got=%b exp=%b", t, bus_b.VGA_HSYNC, got.hs);
            end
            if (bus_b.VGA_VSYNC !== got.vs) begin
                errors++; $display("FAIL sb_vsync t=%0d got=%b exp=%b", t, bus_b.VGA_VSYNC, got.vs);
            end
            if (bus_b.VGA_RGB !== got.rgb) begin
                errors++; $display("FAIL sb_rgb t=%0d got=%0d exp=%0d", t, bus_b.VGA_RGB, got.rgb);
            end
            if (bus_b.oPixelCount !== 11'(mh)) begin
                errors++; $display("FAIL sb_pixcount t=%0d got=%0d exp=%0d", t, bus_b.oPixelCount, mh);
            end
            if (bus_b.oLineCount !== 10'(mv)) begin
                errors++; $display("FAIL sb_linecount t=%0d got=%0d exp=%0d", t, bus_b.oLineCount, mv);
            end
            if (bus_b.oRdCol !== mcol) begin
                errors++; $display("FAIL sb_rdcol t=%0d got=%0d exp=%0d", t, bus_b.oRdCol, mcol);
            end
            if (bus_b.oRdRow !== mrow) begin
                errors++; $display("FAIL sb_rdrow t=%0d got=%0d exp=%0d", t, bus_b.oRdRow, mrow);
            end
            if (bus_b.oFrameStart !== mfs) begin
                errors++; $display("FAIL sb_framestart t=%0d got=%b exp=%b", t, bus_b.oFrameStart, mfs);
            end
            if (int'(bus_b.oRdCol) > max_col) max_col = int'(bus_b.oRdCol);
            if (int'(bus_b.oRdRow) > max_row) max_row = int'(bus_b.oRdRow);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.iEnable = 1'b0; bus_b.iEnable = 1'b0; bus_c.iEnable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 10;
        if (bus_a.oPixelCount !== 11'd0) begin errors++; $display("FAIL reset_a_pix got=%0d exp=0", bus_a.oPixelCount); end
        if (bus_a.oLineCount !== 10'd0)  begin errors++; $display("FAIL reset_a_line got=%0d exp=0", bus_a.oLineCount); end
        if (bus_a.VGA_RGB !== 3'd0)      begin errors++; $display("FAIL reset_a_rgb got=%0d exp=0", bus_a.VGA_RGB); end
        if (bus_a.VGA_HSYNC !== 1'b1)    begin errors++; $display("FAIL reset_a_hsync got=%b exp=1", bus_a.VGA_HSYNC); end
        if (bus_a.VGA_VSYNC !== 1'b1)    begin errors++; $display("FAIL reset_a_vsync got=%b exp=1", bus_a.VGA_VSYNC); end
        if (bus_a.oFrameStart !== 1'b0)  begin errors++; $display("FAIL reset_a_fs got=%b exp=0", bus_a.oFrameStart); end
        if (bus_a.oRdCol !== 11'd0)      begin errors++; $display("FAIL reset_a_rdcol got=%0d exp=0", bus_a.oRdCol); end
        if (bus_b.oRdRow !== 10'd0)      begin errors++; $display("FAIL reset_b_rdrow got=%0d exp=0", bus_b.oRdRow); end
        if (bus_b.VGA_HSYNC !== 1'b1)    begin errors++; $display("FAIL reset_b_hsync got=%b exp=1", bus_b.VGA_HSYNC); end
        if (bus_c.VGA_VSYNC !== 1'b1)    begin errors++; $display("FAIL reset_c_vsync got=%b exp=1", bus_c.VGA_VSYNC); end
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    endtask

    // dut_a line 0: first colour latency, visible width, frame-start pulse width.
    task automatic test_default_line();
        int first, nz, bad, fs_cnt;
        first = -1; nz = 0; bad = 0; fs_cnt = 0;
        @(negedge clk);
        bus_a.iEnable = 1'b1;
        for (int c = 1; c <= 1603; c++) begin
            @(posedge clk);
            #1;
            if (bus_a.oFrameStart === 1'b1) fs_cnt++;
            if (bus_a.VGA_RGB !== 3'd0) begin
                if (first < 0) first = c;
                nz++;
                if (bus_a.VGA_RGB !== 3'b111) bad++;
            end
        end
        checks += 4;
        if (first !== 4)   begin errors++; $display("FAIL a_first_rgb_clock got=%0d exp=4", first); end
        if (nz !== 1280)   begin errors++; $display("FAIL a_visible_clocks got=%0d exp=1280", nz); end
        if (bad !== 0)     begin errors++; $display("FAIL a_rgb_value bad_samples=%0d exp=0", bad); end
        if (fs_cnt !== 1)  begin errors++; $display("FAIL a_framestart_width got=%0d exp=1", fs_cnt); end
    endtask

    task automatic test_line_timing(input int sel, input string name,
                                    input int exp_low, input int exp_period);
        logic prev, hs;
        bit   found, risen, done;
        int   low, per;
        found = 0;
        prev  = hs_of(sel);
        for (int c = 0; c < 8000 && !found; c++) begin
            @(posedge clk);
            #1;
            hs = hs_of(sel);
            if (prev && !hs) found = 1;
            prev = hs;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL %s_hsync_fall timeout got=none exp=falling edge", name);
            return;
        end
        checks++;
        if (pix_of(sel) !== 11'd658) begin
            errors++; $display("FAIL %s_hsync_start_pix got=%0d exp=658", name, pix_of(sel));
        end
        low = 1; per = 0; risen = 0; done = 0; prev = 1'b0;
        while (!done && per < 20000) begin
            @(posedge clk);
            #1;
            per++;
            hs = hs_of(sel);
            if (!risen) begin
                if (hs) risen = 1;
                else    low++;
            end else if (prev && !hs) begin
                done = 1;
            end
            prev = hs;
        end
        checks += 2;
        if (low !== exp_low) begin
            errors++; $display("FAIL %s_hsync_width got=%0d exp=%0d", name, low, exp_low);
        end
        if (!done || per !== exp_period) begin
            errors++; $display("FAIL %s_line_period got=%0d exp=%0d", name, per, exp_period);
        end
    endtask

    task automatic test_clk_div4();
        @(negedge clk);
        bus_c.iEnable = 1'b1;
        test_line_timing(1, "c", 384, 3200);
    endtask

    task automatic test_frame_scoreboard();
        max_col = 0; max_row = 0;
        sb_run(BH_TOTAL * BV_TOTAL + 900);
        checks += 2;
        if (max_col !== 319) begin errors++; $display("FAIL b_max_rdcol got=%0d exp=319", max_col); end
        if (max_row !== 1)   begin errors++; $display("FAIL b_max_rdrow got=%0d exp=1", max_row); end
    endtask

    task automatic test_enable_drop();
        @(negedge clk);
        bus_b.iEnable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks += 5;
        if (bus_b.oPixelCount !== 11'd0) begin errors++; $display("FAIL en_pix got=%0d exp=0", bus_b.oPixelCount); end
        if (bus_b.oLineCount !== 10'd0)  begin errors++; $display("FAIL en_line got=%0d exp=0", bus_b.oLineCount); end
        if (bus_b.VGA_RGB !== 3'd0)      begin errors++; $display("FAIL en_rgb got=%0d exp=0", bus_b.VGA_RGB); end
        if (bus_b.VGA_HSYNC !== 1'b1)    begin errors++; $display("FAIL en_hsync got=%b exp=1", bus_b.VGA_HSYNC); end
        if (bus_b.oRdCol !== 11'd0)      begin errors++; $display("FAIL en_rdcol got=%0d exp=0", bus_b.oRdCol); end
        sb_run(1700);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        bus_b.iEnable = 1'b0;
        @(negedge clk);
        sb_run(2 * BH_TOTAL + 300);
        #1;
        rst_b = 1'b1;
        #1;
        checks += 7;
        if (bus_b.oPixelCount !== 11'd0) begin errors++; $display("FAIL rst_mid_pix got=%0d exp=0", bus_b.oPixelCount); end
        if (bus_b.oLineCount !== 10'd0)  begin errors++; $display("FAIL rst_mid_line got=%0d exp=0", bus_b.oLineCount); end
        if (bus_b.VGA_RGB !== 3'd0)      begin errors++; $display("FAIL rst_mid_rgb got=%0d exp=0", bus_b.VGA_RGB); end
        if (bus_b.oFrameStart !== 1'b0)  begin errors++; $display("FAIL rst_mid_fs got=%b exp=0", bus_b.oFrameStart); end
        if (bus_b.VGA_HSYNC !== 1'b1)    begin errors++; $display("FAIL rst_mid_hsync got=%b exp=1", bus_b.VGA_HSYNC); end
        if (bus_b.VGA_VSYNC !== 1'b1)    begin errors++; $display("FAIL rst_mid_vsync got=%b exp=1", bus_b.VGA_VSYNC); end
        if (bus_b.oRdCol !== 11'd0)      begin errors++; $display("FAIL rst_mid_rdcol got=%0d exp=0", bus_b.oRdCol); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        sb_run(100);
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_line_timing(0, "a", 192, 1600);
        test_clk_div4();
        test_frame_scoreboard();
        test_enable_drop();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
